// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: slave endpoint of the RTC multiplexed address/data bus,
// backed by a BCD time/date register file advanced by a divided second tick.
module rtc_bus_responder #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       ad,
  input  logic       rd_n,
  input  logic       wr_n,
  inout  wire  [7:0] dat_io,
  output logic       sec_pulse
);

  localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_e;

  // sampled bus
  logic       s_cs_n_q, s_ad_q, s_rd_n_q, s_wr_n_q;
  logic [7:0] s_dat_q;

  // bus FSM
  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wlat_q, wlat_d;
  logic [7:0] rdat_q, rdat_d;
  logic       drive_q, drive_d;
  logic       wr_commit;
  logic [7:0] rd_mux;

  // register file and timebase
  logic             halt_q, halt_d;
  logic [7:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [7:0]       day_q, day_d, mon_q, mon_d, year_q, year_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sec_pulse_q, sec_pulse_d;
  logic             tick;
  logic             c_min, c_hour, c_day, c_mon, c_year;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'h9) bcd_inc = {v[7:4] + 4'h1, 4'h0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'h1};
  endfunction

  // Leap on BCD year: tens even with units 0/4/8, or tens odd with units 2/6.
  function automatic logic is_leap(input logic [7:0] yr);
    if (yr[4]) is_leap = (yr[3:0] == 4'h2) || (yr[3:0] == 4'h6);
    else       is_leap = (yr[3:0] == 4'h0) || (yr[3:0] == 4'h4) || (yr[3:0] == 4'h8);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] mon, input logic [7:0] yr);
    case (mon)
      8'h02:                      month_len = is_leap(yr) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      default:                    month_len = 8'h31;
    endcase
  endfunction

  // Read mux over the register map; unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (addr_q)
      8'h00:   rd_mux = {7'b0, halt_q};
      8'h21:   rd_mux = sec_q;
      8'h22:   rd_mux = min_q;
      8'h23:   rd_mux = hour_q;
      8'h24:   rd_mux = day_q;
      8'h25:   rd_mux = mon_q;
      8'h26:   rd_mux = year_q;
      default: rd_mux = '0;
    endcase
  end

  // Bus FSM: decode sampled strobes, latch address, commit writes, snapshot reads.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wlat_d    = wlat_q;
    rdat_d    = rdat_q;
    wr_commit = 1'b0;
    // Keep the bus value of the most recent cycle with wr_n low; it is what
    // gets committed once the rising wr_n edge is seen.
    if (!s_wr_n_q) wlat_d = s_dat_q;
    if (s_cs_n_q || (!s_rd_n_q && !s_wr_n_q)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!s_wr_n_q) begin
            state_d = s_ad_q ? WDATA : ADDR;
          end else if (!s_rd_n_q && s_ad_q) begin
            state_d = RDATA;
            rdat_d  = rd_mux;
          end
        end
        ADDR: begin
          if (s_wr_n_q) begin
            addr_d  = wlat_q;
            state_d = IDLE;
          end
        end
        WDATA: begin
          if (s_wr_n_q) begin
            wr_commit = 1'b1;
            state_d   = IDLE;
          end
        end
        RDATA: begin
          if (s_rd_n_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    drive_d = (state_d == RDATA);
  end

  // Timebase and BCD carry chain; a host write overrides only its own field.
  always_comb begin
    tick        = !halt_q && (div_q == DIV_LAST);
    div_d       = (halt_q || tick) ? '0 : div_q + DIV_W'(1);
    sec_pulse_d = tick;
    halt_d      = halt_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    day_d       = day_q;
    mon_d       = mon_q;
    year_d      = year_q;
    c_min       = 1'b0;
    c_hour      = 1'b0;
    c_day       = 1'b0;
    c_mon       = 1'b0;
    c_year      = 1'b0;
    if (tick) begin
      if (sec_q >= 8'h59) begin sec_d = 8'h00; c_min = 1'b1; end
      else                      sec_d = bcd_inc(sec_q);
    end
    if (c_min) begin
      if (min_q >= 8'h59) begin min_d = 8'h00; c_hour = 1'b1; end
      else                      min_d = bcd_inc(min_q);
    end
    if (c_hour) begin
      if (hour_q >= 8'h23) begin hour_d = 8'h00; c_day = 1'b1; end
      else                       hour_d = bcd_inc(hour_q);
    end
    if (c_day) begin
      if (day_q >= month_len(mon_q, year_q)) begin day_d = 8'h01; c_mon = 1'b1; end
      else                                         day_d = bcd_inc(day_q);
    end
    if (c_mon) begin
      if (mon_q >= 8'h12) begin mon_d = 8'h01; c_year = 1'b1; end
      else                      mon_d = bcd_inc(mon_q);
    end
    if (c_year) begin
      if (year_q >= 8'h99) year_d = 8'h00;
      else                 year_d = bcd_inc(year_q);
    end
    if (wr_commit) begin
      case (addr_q)
        8'h00:   halt_d = wlat_q[0];
        8'h21:   sec_d  = wlat_q;
        8'h22:   min_d  = wlat_q;
        8'h23:   hour_d = wlat_q;
        8'h24:   day_d  = wlat_q;
        8'h25:   mon_d  = wlat_q;
        8'h26:   year_d = wlat_q;
        default: ;
      endcase
    end
  end

  // State registers: bus sampling, FSM, register file, divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_cs_n_q    <= 1'b1;
      s_ad_q      <= 1'b0;
      s_rd_n_q    <= 1'b1;
      s_wr_n_q    <= 1'b1;
      s_dat_q     <= '0;
      state_q     <= IDLE;
      addr_q      <= '0;
      wlat_q      <= '0;
      rdat_q      <= '0;
      drive_q     <= 1'b0;
      halt_q      <= 1'b0;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      day_q       <= 8'h01;
      mon_q       <= 8'h01;
      year_q      <= 8'h00;
      div_q       <= '0;
      sec_pulse_q <= 1'b0;
    end else begin
      s_cs_n_q    <= cs_n;
      s_ad_q      <= ad;
      s_rd_n_q    <= rd_n;
      s_wr_n_q    <= wr_n;
      s_dat_q     <= dat_io;
      state_q     <= state_d;
      addr_q      <= addr_d;
      wlat_q      <= wlat_d;
      rdat_q      <= rdat_d;
      drive_q     <= drive_d;
      halt_q      <= halt_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      mon_q       <= mon_d;
      year_q      <= year_d;
      div_q       <= div_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end

  assign dat_io    = drive_q ? rdat_q : 'z;
  assign sec_pulse = sec_pulse_q;

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Bus-side responder for the RTC's multiplexed 8-bit address/data interface: it decodes the CS/AD/RD/WR strobes issued by the RTC controller, latches an address, accepts register writes and drives register reads onto the shared bus. Behind the bus it holds a BCD time/date register file advanced by a divided second tick. Used as the RTC chip model in system simulation and as the slave endpoint when the RTC is emulated in FPGA fabric.

## Interface
- TICK_DIV, 100000000: clk cycles per second tick (≥ 4).
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- cs_n  in  1  chip select, active low.
- ad  in  1  phase select: 0 = address phase, 1 = data phase.
- rd_n  in  1  read strobe, active low.
- wr_n  in  1  write strobe, active low.
- dat_io  inout  8  multiplexed address/data bus; driven only during read data phase, else Z.
- sec_pulse  out  1  one-cycle pulse on each second tick applied to the counters.

## Operation
- Register map (BCD): 0x00 control (bit0 = HALT, others read 0), 0x21 sec 00-59, 0x22 min 00-59, 0x23 hour 00-23, 0x24 day 01-31, 0x25 month 01-12, 0x26 year 00-99. Unmapped addresses: writes ignored, reads return 0x00.
- Bus inputs cs_n/ad/rd_n/wr_n/dat_io registered once (s_* = sampled copies); all decoding uses sampled values.
- FSM states: IDLE, ADDR, WDATA, RDATA.
  - IDLE → ADDR: s_cs_n=0, s_ad=0, s_wr_n=0.
  - IDLE → WDATA: s_cs_n=0, s_ad=1, s_wr_n=0.
  - IDLE → RDATA: s_cs_n=0, s_ad=1, s_rd_n=0.
  - ADDR → IDLE on s_wr_n rising: addr_reg ← sampled bus value from the last cycle with s_wr_n=0.
  - WDATA → IDLE on s_wr_n rising: register[addr_reg] ← sampled bus value from the last cycle with s_wr_n=0.
  - RDATA → IDLE on s_rd_n=1.
  - Any state → IDLE when s_cs_n=1; pending write discarded.
  - s_rd_n=0 and s_wr_n=0 together: ignored, FSM goes/stays IDLE, no drive.
- Read data snapshot taken on RDATA entry; held constant while in RDATA (no tearing if a tick occurs mid-read).
- addr_reg persists across transactions; data phases reuse it, no auto-increment.
- Timekeeping: divider counts 0..TICK_DIV-1; at terminal count, if HALT=0, sec_pulse=1 and sec increments with BCD carry chain sec→min→hour→day→month→year. With HALT=1 divider holds at 0, no pulses.
- Day wrap per month: 31 (1,3,5,7,8,10,12), 30 (4,6,9,11), Feb 28, Feb 29 if year is leap (BCD tens even and units ∈{0,4,8}, or tens odd and units ∈{2,6}). Year 99 → 00.
- Any field at or above its maximum (incl. non-BCD values written by host) wraps to its minimum on next increment and carries.
- Write and tick in same cycle: written register takes the written value; other fields apply tick normally (carry into the written field is lost).

## Timing
- Reset values: dat_io Z, sec_pulse 0, FSM IDLE, addr_reg 0x00, control 0x00, sec/min/hour 00, day 01, month 01, year 00, divider 0.
- Read drive: dat_io driven from the 2nd clk edge after rd_n falls (1 sync + 1 FSM), released (Z) at the 2nd clk edge after rd_n or cs_n rises.
- Write commit: register updated at the 2nd clk edge after wr_n rises; readable in the next transaction.
- Host must hold strobes low ≥ 3 clk and keep bus stable around wr_n rise ≥ 2 clk.
- sec_pulse: exactly 1 cycle wide, period TICK_DIV cycles; first pulse TICK_DIV cycles after reset release.

## Test plan
- Reset, then read 0x21..0x26 with TICK_DIV=16 before first tick → 0x00,0x00,0x00,0x01,0x01,0x00; dat_io Z between reads.
- Write addr 0x22, data 0x45; read back → 0x45; read of unmapped 0x30 → 0x00; write to 0x30 changes nothing.
- Preset 23:59:59 on 31/12/99, one tick → sec 00, min 00, hour 00, day 01, month 01, year 00; sec_pulse one cycle high.
- Preset 28/02/24 23:59:59, tick → 29/02; preset 28/02/23 same → 01/03; preset 30/04 23:59:59 → 01/05.
- Set HALT (0x00 ← 0x01) and wait 3×TICK_DIV → no sec_pulse, sec unchanged; clear HALT → ticking resumes.
- Abort: wr_n low in data phase then cs_n high before wr_n rises → no register change; rd_n+wr_n both low → bus stays Z, no write.
